validador_codigo: RTL and testbench
===================================

# validador_codigo

Access-code validator that sits directly upstream of the coffee-machine controller (`circuito_eletrico`). It samples the 7-bit user code on a confirm strobe, grants or refuses authorisation, and counts failed attempts. It locks the keypad out for a fixed time after too many failures and drops authorisation after a period without user activity. The controller only accepts `selecao`/`start` while `autorizado` is high.

## Interface
- `CODIGO_OK`, 7'b0010001: accepted access code.
- `MAX_TENTATIVAS`, 3: failed attempts that trigger lockout (range 1..3).
- `BLOQUEIO_CICLOS`, 10: lockout duration in clock cycles (≥1).
- `SESSAO_CICLOS`, 30: idle cycles before an authorised session expires (≥2).

- `CLK`  in  1: single clock, all state on rising edge.
- `RST`  in  1: reset; synchronous, active-high.
- `power`  in  1: machine power switch, level.
- `codigo`  in  7: user code, sampled only on a confirm edge.
- `confirmar`  in  1: confirm key, level; a 0→1 transition is one entry.
- `atividade`  in  1: from the controller, high in any cycle with selection or start activity.
- `autorizado`  out  1: high while in AUTORIZADO.
- `bloqueado`  out  1: high while in BLOQUEADO.
- `erro`  out  1: one-cycle pulse per rejected code.
- `tentativas`  out  2: current failed-attempt count.
- `estado_val`  out  2: DESLIGADO=0, ESPERA=1, AUTORIZADO=2, BLOQUEADO=3.

## Operation
- Edge detect: register `conf_q`. `entrada = confirmar & ~conf_q`. A held key counts once.
- DESLIGADO: all entries are ignored. `power=1` → ESPERA.
- ESPERA, on `entrada`:
  - If `codigo==CODIGO_OK`: → AUTORIZADO, `tentativas`←0, session counter ← SESSAO_CICLOS−1.
  - Otherwise: `erro`=1 for one cycle and `tentativas`+1. If the new count equals MAX_TENTATIVAS: → BLOQUEADO, lockout counter ← BLOQUEIO_CICLOS−1.
- AUTORIZADO:
  - A cycle with `atividade=1` reloads the session counter. Otherwise it decrements.
  - Counter at 0 with no activity → ESPERA.
  - Further `entrada` edges are ignored.
- BLOQUEADO:
  - The lockout counter decrements every cycle, regardless of `power`. Power-cycling does not bypass lockout.
  - At 0: `tentativas`←0, then → ESPERA if `power=1`, else → DESLIGADO.
  - Entries are ignored and do not count.
- `power=0` in ESPERA or AUTORIZADO → DESLIGADO. Authorisation is lost. `tentativas` is kept; failures accumulate across power cycles until a success or a lockout expiry.
- Simultaneous events:
  - `power=0` with `entrada` in ESPERA: power wins, the entry is discarded, no `erro`.
  - `atividade` together with session expiry: activity wins, the session stays.
  - `RST` overrides everything.
- All counters saturate and never wrap. `tentativas` never exceeds MAX_TENTATIVAS.

## Timing
- Reset values: state DESLIGADO, `autorizado=0`, `bloqueado=0`, `erro=0`, `tentativas=0`, `estado_val=0`, `conf_q=0`, both counters 0.
- Outputs are registered, Moore-decoded from state, or registered directly (`erro`, `tentativas`).
- Latency is 1 cycle: a `confirmar` rise sampled at edge k changes outputs after edge k.
- Authorised session lasts exactly SESSAO_CICLOS idle cycles after the last activity or grant.
- Lockout lasts exactly BLOQUEIO_CICLOS cycles with `bloqueado=1`.
- Power transitions take effect at the next edge.
- `RST` asserted mid-session or mid-lockout: DESLIGADO after that edge, all counts cleared.

## Structure
- Shared package `pkg_cafe`: state encoding constants (DESLIGADO..BLOQUEADO), default CODIGO_OK, code width 7. The controller reuses these.
- One sub-module, `contador_descendente`: a parameter-width, loadable, saturating-at-zero down counter with `load`, `valor`, `en`, and a `zero` output. Instantiated twice, for the session and lockout counters.
- The FSM and edge detect live in the top module.

## Test plan
- Reset, then `power=1`, `codigo=7'b0010001`, one `confirmar` pulse → `estado_val` 0→1→2 and `autorizado=1` one cycle after the confirm edge, `tentativas=0`.
- Three confirms with `codigo=7'b0010011` → three single-cycle `erro` pulses and `tentativas` 1,2,3. After the third: `bloqueado=1` for exactly 10 cycles, then ESPERA with `tentativas=0`.
- During lockout: a correct code plus `power` toggled 0→1 → no authorisation, `bloqueado` stays 1 for the full 10 cycles.
- Authorised, no activity → `autorizado` falls after exactly 30 cycles. Same test with an `atividade` pulse at cycle 20 → it falls 30 cycles after that pulse.
- `confirmar` held high for 5 cycles with a wrong code → exactly one `erro`, `tentativas=1`. `power=0` with `entrada` on the same edge → DESLIGADO, no `erro`.
- `RST` asserted mid-lockout at cycle 4 → all outputs at reset values after that edge.

Source files
------------

// File: rtl/validador_codigo_pkg.sv
// Shared coffee-machine definitions: access-validator state encoding and code format.
// The downstream controller imports the same package.
package pkg_cafe;

  localparam int CODIGO_W = 7;
  localparam logic [CODIGO_W-1:0] CODIGO_PADRAO = 7'b0010001;

  typedef enum logic [1:0] {
    DESLIGADO  = 2'd0,
    ESPERA     = 2'd1,
    AUTORIZADO = 2'd2,
    BLOQUEADO  = 2'd3
  } estado_t;

endpackage

// File: rtl/validador_codigo_contador.sv
// Loadable down counter that stops at zero; load has priority over decrement.
module contador_descendente #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] valor,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                  cnt <= '0;
    else if (load)            cnt <= valor;
    else if (en && cnt != '0) cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/validador_codigo.sv
// Access-code validator: grants sessions on the right code, counts failures,
// locks the keypad after too many, and expires idle sessions.
module validador_codigo
  import pkg_cafe::*;
#(
  parameter logic [CODIGO_W-1:0] CODIGO_OK       = CODIGO_PADRAO,
  parameter int                  MAX_TENTATIVAS  = 3,
  parameter int                  BLOQUEIO_CICLOS = 10,
  parameter int                  SESSAO_CICLOS   = 30
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                power,
  input  logic [CODIGO_W-1:0] codigo,
  input  logic                confirmar,
  input  logic                atividade,
  output logic                autorizado,
  output logic                bloqueado,
  output logic                erro,
  output logic [1:0]          tentativas,
  output logic [1:0]          estado_val
);

  localparam int SW = $clog2(SESSAO_CICLOS);
  localparam int BW = (BLOQUEIO_CICLOS > 1) ? $clog2(BLOQUEIO_CICLOS) : 1;
  localparam logic [1:0] MAX_T = 2'(MAX_TENTATIVAS);

  estado_t    st, nxt;
  logic       conf_q, entrada;
  logic       erro_n;
  logic [1:0] tent_n;
  logic       ses_load, ses_en, ses_zero;
  logic       blq_load, blq_en, blq_zero;

  assign entrada = confirmar & ~conf_q;

  always_comb begin
    nxt      = st;
    erro_n   = 1'b0;
    tent_n   = tentativas;
    ses_load = 1'b0;
    blq_load = 1'b0;
    case (st)
      DESLIGADO: if (power) nxt = ESPERA;
      ESPERA: begin
        // Power loss discards a simultaneous entry entirely.
        if (!power) nxt = DESLIGADO;
        else if (entrada) begin
          if (codigo == CODIGO_OK) begin
            nxt      = AUTORIZADO;
            tent_n   = 2'd0;
            ses_load = 1'b1;
          end else begin
            erro_n = 1'b1;
            if (tentativas < MAX_T) tent_n = tentativas + 2'd1;
            if (tent_n == MAX_T) begin
              nxt      = BLOQUEADO;
              blq_load = 1'b1;
            end
          end
        end
      end
      AUTORIZADO: begin
        if (!power)         nxt = DESLIGADO;
        else if (atividade) ses_load = 1'b1;
        else if (ses_zero)  nxt = ESPERA;
      end
      BLOQUEADO: begin
        // Lockout runs out regardless of power; power only picks the exit state.
        if (blq_zero) begin
          tent_n = 2'd0;
          nxt    = power ? ESPERA : DESLIGADO;
        end
      end
      default: nxt = DESLIGADO;
    endcase
  end

  assign ses_en = (st == AUTORIZADO);
  assign blq_en = (st == BLOQUEADO);

  contador_descendente #(.W(SW)) u_sessao (
    .clk  (CLK),
    .rst  (RST),
    .load (ses_load),
    .en   (ses_en),
    .valor(SW'(SESSAO_CICLOS - 1)),
    .zero (ses_zero)
  );

  contador_descendente #(.W(BW)) u_bloqueio (
    .clk  (CLK),
    .rst  (RST),
    .load (blq_load),
    .en   (blq_en),
    .valor(BW'(BLOQUEIO_CICLOS - 1)),
    .zero (blq_zero)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      st         <= DESLIGADO;
      conf_q     <= 1'b0;
      erro       <= 1'b0;
      tentativas <= 2'd0;
      autorizado <= 1'b0;
      bloqueado  <= 1'b0;
      estado_val <= 2'd0;
    end else begin
      st         <= nxt;
      conf_q     <= confirmar;
      erro       <= erro_n;
      tentativas <= tent_n;
      autorizado <= (nxt == AUTORIZADO);
      bloqueado  <= (nxt == BLOQUEADO);
      estado_val <= nxt;
    end
  end

endmodule

// File: tb/tb_validador_codigo.sv
// Bench for validador_codigo: directed scenarios with literal expectations,
// then random stimulus, all outputs compared every cycle against a timestamp model.
module tb_validador_codigo;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       power = 1'b0;
  logic [6:0] codigo = 7'd0;
  logic       confirmar = 1'b0;
  logic       atividade = 1'b0;
  logic       autorizado, bloqueado, erro;
  logic [1:0] tentativas, estado_val;

  localparam logic [6:0] OK  = 7'b0010001;
  localparam logic [6:0] BAD = 7'b0010011;

  validador_codigo dut (
    .CLK(CLK), .RST(RST), .power(power), .codigo(codigo), .confirmar(confirmar),
    .atividade(atividade), .autorizado(autorizado), .bloqueado(bloqueado),
    .erro(erro), .tentativas(tentativas), .estado_val(estado_val)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0..3 as the state names; deadlines kept as edge timestamps.
  int t = 0;
  int m_mode = 0, m_tent = 0, m_erro = 0, m_last = 0, m_lock = 0, m_confq = 0;
  bit chk_en = 0;

  always @(posedge CLK) begin
    automatic bit ent = confirmar && !m_confq;
    t++;
    if (RST) begin
      m_mode = 0; m_tent = 0; m_erro = 0; m_confq = 0;
    end else begin
      m_erro = 0;
      case (m_mode)
        0: if (power) m_mode = 1;
        1: if (!power) m_mode = 0;
           else if (ent) begin
             if (codigo == OK) begin m_mode = 2; m_tent = 0; m_last = t; end
             else begin
               m_erro = 1;
               m_tent = m_tent + 1;
               if (m_tent == 3) begin m_mode = 3; m_lock = t; end
             end
           end
        2: if (!power) m_mode = 0;
           else if (atividade) m_last = t;
           else if (t - m_last >= 30) m_mode = 1;
        default: if (t - m_lock >= 10) begin m_tent = 0; m_mode = power ? 1 : 0; end
      endcase
      m_confq = confirmar;
    end
    if (RST) chk_en = 1;
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("estado_val", estado_val, m_mode);
      chk("autorizado", autorizado, m_mode == 2);
      chk("bloqueado", bloqueado, m_mode == 3);
      chk("erro", erro, m_erro);
      chk("tentativas", tentativas, m_tent);
    end
  end

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic wrong_entry();
    codigo = BAD; confirmar = 1'b1; step(); confirmar = 1'b0;
  endtask

  initial begin
    int n;
    // Reset and grant
    RST = 1'b1; step(); RST = 1'b0;
    chk("rst estado", estado_val, 0); chk("rst tent", tentativas, 0);
    chk("rst aut", autorizado, 0); chk("rst blq", bloqueado, 0); chk("rst erro", erro, 0);
    power = 1'b1; step();
    chk("on estado", estado_val, 1);
    codigo = OK; confirmar = 1'b1; step(); confirmar = 1'b0;
    chk("grant estado", estado_val, 2); chk("grant aut", autorizado, 1);
    chk("grant tent", tentativas, 0);

    // Idle session length
    n = 1;
    for (int i = 0; i < 100; i++) begin step(); if (autorizado) n++; else break; end
    chk("session idle len", n, 30);
    chk("session end estado", estado_val, 1);

    // Activity at cycle 20 restarts the window
    codigo = OK; confirmar = 1'b1; step(); confirmar = 1'b0;
    for (int i = 0; i < 19; i++) step();
    atividade = 1'b1; step(); atividade = 1'b0;
    n = 1;
    for (int i = 0; i < 100; i++) begin step(); if (autorizado) n++; else break; end
    chk("session after act len", n, 30);

    // Three failures then lockout
    for (int i = 1; i <= 3; i++) begin
      wrong_entry();
      chk("wrong erro", erro, 1); chk("wrong tent", tentativas, i);
      if (i < 3) begin step(); chk("erro single", erro, 0); end
    end
    n = 1;
    for (int i = 0; i < 100; i++) begin step(); if (bloqueado) n++; else break; end
    chk("lockout len", n, 10);
    chk("post lock estado", estado_val, 1); chk("post lock tent", tentativas, 0);

    // Lockout survives a correct code and a power toggle
    for (int i = 0; i < 3; i++) begin wrong_entry(); if (i < 2) step(); end
    n = 1;
    for (int i = 1; i < 100; i++) begin
      if (i == 2) begin codigo = OK; confirmar = 1'b1; end
      if (i == 3) begin confirmar = 1'b0; power = 1'b0; end
      if (i == 5) power = 1'b1;
      step();
      if (bloqueado) n++; else break;
    end
    chk("lockout bypass len", n, 10);
    chk("bypass aut", autorizado, 0);

    // Held confirm counts once
    n = 0; codigo = BAD; confirmar = 1'b1;
    for (int i = 0; i < 5; i++) begin step(); n += erro; end
    confirmar = 1'b0; step();
    chk("held erro count", n, 1); chk("held tent", tentativas, 1);

    // Power-off with simultaneous entry
    confirmar = 1'b1; power = 1'b0; step();
    chk("pwr off estado", estado_val, 0); chk("pwr off erro", erro, 0);
    chk("pwr off tent kept", tentativas, 1);
    confirmar = 1'b0; power = 1'b1; step();

    // Reset mid-lockout
    wrong_entry(); step(); wrong_entry();
    chk("relock blq", bloqueado, 1);
    for (int i = 0; i < 3; i++) step();
    RST = 1'b1; step(); RST = 1'b0;
    chk("midlock rst estado", estado_val, 0); chk("midlock rst blq", bloqueado, 0);
    chk("midlock rst tent", tentativas, 0); chk("midlock rst erro", erro, 0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      power     = ($urandom_range(0, 19) != 0);
      confirmar = ($urandom_range(0, 2) == 0);
      codigo    = ($urandom_range(0, 2) == 0) ? OK : 7'($urandom);
      atividade = ($urandom_range(0, 9) == 0);
      RST       = ($urandom_range(0, 299) == 0);
      step();
    end
    RST = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
